// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared defaults, BCD digit width and converter FSM states
package stopwatch_pkg;
  localparam int DIGITS_DEF = 8;
  localparam int BIN_W_DEF = 27;
  localparam int DIGIT_W = 4;
  typedef enum logic [1:0] {IDLE, CONVERT, DONE} state_t;
  function automatic logic digit_invalid(input logic [DIGIT_W-1:0] d);
    return d > 4'd9;
  endfunction
endpackage

// File: rtl/bcd_digit_corrector.sv
// bcd_digit_corrector: reverse double-dabble digit adjust (>=8 -> -3)
// Ports: digit (4-bit shifted BCD digit in), fixed (4-bit adjusted digit out)
module bcd_digit_corrector
  import stopwatch_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  output logic [DIGIT_W-1:0] fixed
);
  assign fixed = digit >= 4'd8 ? digit - 4'd3 : digit;
endmodule

// File: rtl/bcd_to_hex_converter.sv
// bcd_to_hex_converter: sequential packed-BCD to binary via reverse double-dabble
// Ports: Clock, Reset (sync, active-high), Start, bcd_in (digit 0 in [3:0]),
//        Busy, Done (1-cycle pulse), hex_number (held until next Done), Error.
// Define BCD_CHECK_EN to flag digits > 9 (Error=1, hex_number=0); otherwise Error is tied 0.
module bcd_to_hex_converter
  import stopwatch_pkg::*;
#(
  parameter int DIGITS = DIGITS_DEF,
  parameter int BIN_W = BIN_W_DEF
) (
  input  logic                      Clock,
  input  logic                      Reset,
  input  logic                      Start,
  input  logic [DIGIT_W*DIGITS-1:0] bcd_in,
  output logic                      Busy,
  output logic                      Done,
  output logic [BIN_W-1:0]          hex_number,
  output logic                      Error
);
  localparam int BCD_BITS = DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  state_t state;
  logic [BCD_BITS-1:0] bcd_sr, bcd_shift, bcd_fix;
  logic [BIN_W-1:0] bin_sr, bin_next, result;
  logic [CNT_W-1:0] cnt;
  logic last;
  logic unused_lsb;
  // The binary LSB falls off the end; it is only ever zero before the final shift.
  assign unused_lsb = bin_sr[0];
  assign bcd_shift = {1'b0, bcd_sr[BCD_BITS-1:1]};
  assign bin_next = {bcd_sr[0], bin_sr[BIN_W-1:1]};
  assign last = cnt == CNT_W'(BIN_W - 1);
  for (genvar g = 0; g < DIGITS; g++) begin : g_fix
    bcd_digit_corrector u_fix (
      .digit(bcd_shift[DIGIT_W*g +: DIGIT_W]),
      .fixed(bcd_fix[DIGIT_W*g +: DIGIT_W])
    );
  end
`ifdef BCD_CHECK_EN
  logic flag, bad;
  always_comb begin
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) bad = bad | digit_invalid(bcd_in[DIGIT_W*i +: DIGIT_W]);
  end
  assign result = flag ? '0 : bin_next;
  always_ff @(posedge Clock)
    if (Reset) begin
      flag <= 1'b0;
      Error <= 1'b0;
    end else begin
      if (state == IDLE && Start) flag <= bad;
      if (state == CONVERT && last) Error <= flag;
    end
`else
  assign result = bin_next;
  assign Error = 1'b0;
`endif
  always_ff @(posedge Clock)
    if (Reset) begin
      state <= IDLE;
      Busy <= 1'b0;
      Done <= 1'b0;
      hex_number <= '0;
      bcd_sr <= '0;
      bin_sr <= '0;
      cnt <= '0;
    end else begin
      Done <= 1'b0;
      unique case (state)
        IDLE:
          if (Start) begin
            state <= CONVERT;
            Busy <= 1'b1;
            bcd_sr <= bcd_in;
            bin_sr <= '0;
            cnt <= '0;
          end
        CONVERT: begin
          bcd_sr <= bcd_fix;
          bin_sr <= bin_next;
          cnt <= cnt + 1'b1;
          if (last) begin
            state <= DONE;
            Busy <= 1'b0;
            Done <= 1'b1;
            hex_number <= result;
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_bcd_to_hex_converter.sv
// tb_bcd_to_hex_converter: directed self-checking bench for bcd_to_hex_converter
module tb_bcd_to_hex_converter;
  logic Clock = 1'b0, Reset = 1'b1, Start = 1'b0;
  logic [31:0] bcd_in = '0;
  logic Busy, Done, Error;
  logic [26:0] hex_number;
  int tests = 0, fails = 0;

  bcd_to_hex_converter dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .bcd_in(bcd_in),
    .Busy(Busy), .Done(Done), .hex_number(hex_number), .Error(Error)
  );

  always #10 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle_no_done(input string tag, input int n);
    int pulses = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge Clock);
      if (Done) pulses++;
    end
    check(tag, pulses, 0);
  endtask

  task automatic convert(input string tag, input logic [31:0] bcd, input logic [31:0] exp_hex,
                         input logic exp_err, input int inj, input logic [31:0] inj_bcd);
    int k = 0, busy_n = 0;
    bcd_in = bcd;
    Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    while (!Done && k < 60) begin
      if (Busy) busy_n++;
      if (k == inj) begin
        Start = 1'b1;
        bcd_in = inj_bcd;
      end else Start = 1'b0;
      @(negedge Clock);
      k++;
    end
    Start = 1'b0;
    check({tag, "_lat"}, k, 27);
    check({tag, "_busy_cycles"}, busy_n, 27);
    check({tag, "_busy_in_done"}, Busy, 0);
    check({tag, "_hex"}, hex_number, exp_hex);
    check({tag, "_err"}, Error, exp_err);
    @(negedge Clock);
    check({tag, "_done_width"}, Done, 0);
  endtask

  initial begin
    int k, gap;
    repeat (3) @(negedge Clock);
    Reset = 1'b0;
    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);
    check("rst_err", Error, 0);
    check("rst_hex", hex_number, 0);
    convert("basic", 32'h12345678, 32'hBC614E, 1'b0, -1, 0);
    convert("max", 32'h99999999, 32'h5F5E0FF, 1'b0, -1, 0);
    convert("zero", 32'h00000000, 32'h0, 1'b0, -1, 0);
    convert("ignore", 32'h12345678, 32'hBC614E, 1'b0, 10, 32'h00000042);
    idle_no_done("ignore_no_second", 40);
    bcd_in = 32'h99999999;
    Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    repeat (15) @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    check("midrst_busy", Busy, 0);
    check("midrst_done", Done, 0);
    check("midrst_err", Error, 0);
    check("midrst_hex", hex_number, 0);
    idle_no_done("midrst_no_done", 40);
    convert("after_rst", 32'h00000042, 32'h2A, 1'b0, -1, 0);
`ifdef BCD_CHECK_EN
    convert("invalid", 32'h0000001A, 32'h0, 1'b1, -1, 0);
    convert("valid_after_bad", 32'h00000042, 32'h2A, 1'b0, -1, 0);
`else
    bcd_in = 32'h0000001A;
    Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    k = 0;
    while (!Done && k < 60) begin
      @(negedge Clock);
      k++;
    end
    check("invalid_lat", k, 27);
    check("invalid_err", Error, 0);
    @(negedge Clock);
`endif
    bcd_in = 32'h00000001;
    Start = 1'b1;
    k = 0;
    while (!Done && k < 60) begin
      @(negedge Clock);
      k++;
    end
    check("b2b_first_hex", hex_number, 1);
    for (int r = 0; r < 3; r++) begin
      @(negedge Clock);
      gap = 1;
      while (!Done && gap < 80) begin
        @(negedge Clock);
        gap++;
      end
      check("b2b_gap", gap, 29);
      check("b2b_hex", hex_number, 1);
    end
    Start = 1'b0;
    repeat (40) @(negedge Clock);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
